// File: rtl/game_state_controller_pkg.sv
// Shared constants, state encoding and car-period helper for the round/level sequencer.
package game_state_controller_pkg;

    localparam int unsigned LIVES_INI_DEF     = 3;
    localparam int unsigned MAX_LEVEL_DEF     = 9;
    localparam int unsigned FREEZE_FRAMES_DEF = 60;
    localparam int unsigned WIN_Y_DEF         = 0;
    localparam int unsigned BASE_PERIOD_DEF   = 250000;
    localparam int unsigned PERIOD_STEP_DEF   = 20000;

    localparam int unsigned STATE_W  = 3;
    localparam int unsigned LIVES_W  = 2;
    localparam int unsigned LEVEL_W  = 4;
    localparam int unsigned PERIOD_W = 20;
    localparam int unsigned FRAME_W  = 8;
    localparam int unsigned FROG_Y_W = 10;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_PLAY     = 3'd1,
        ST_HIT      = 3'd2,
        ST_LEVEL_UP = 3'd3,
        ST_OVER     = 3'd4
    } state_e;

    // Car step period for a 1-based level; parameters guarantee no underflow.
    function automatic logic [PERIOD_W-1:0] car_period(
        input logic [PERIOD_W-1:0] base,
        input logic [PERIOD_W-1:0] step,
        input logic [LEVEL_W-1:0]  level
    );
        logic [PERIOD_W-1:0] idx;
        idx = PERIOD_W'(level) - PERIOD_W'(1);
        return base - PERIOD_W'(idx * step);
    endfunction

endpackage

// File: rtl/game_state_controller_if.sv
// Game-state bus: play inputs from collision/frog logic, state outputs to the rest of the game.
interface game_state_controller_if;
    import game_state_controller_pkg::*;

    logic                i_Frame_Tick;
    logic                i_Any_Switch;
    logic                i_Has_Collided;
    logic [FROG_Y_W-1:0] i_Frog_Y;
    logic [STATE_W-1:0]  o_State;
    logic [LIVES_W-1:0]  o_Lives;
    logic [LEVEL_W-1:0]  o_Level;
    logic [PERIOD_W-1:0] o_Car_Period;
    logic                o_Frog_Reset;
    logic                o_Game_Active;

    modport master (
        output i_Frame_Tick, i_Any_Switch, i_Has_Collided, i_Frog_Y,
        input  o_State, o_Lives, o_Level, o_Car_Period, o_Frog_Reset, o_Game_Active
    );

    modport slave (
        input  i_Frame_Tick, i_Any_Switch, i_Has_Collided, i_Frog_Y,
        output o_State, o_Lives, o_Level, o_Car_Period, o_Frog_Reset, o_Game_Active
    );

endinterface

// File: rtl/game_state_controller_frame_delay_counter.sv
// Counts frame ticks up to FRAMES and holds there; clear restarts the freeze interval.
module game_state_controller_frame_delay_counter
    import game_state_controller_pkg::*;
#(
    parameter int unsigned FRAMES = FREEZE_FRAMES_DEF
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Clear,
    input  logic i_Tick,
    output logic o_Done_c
);

    logic [FRAME_W-1:0] r_count;

    // Clear has priority so a tick in the entry cycle is not counted.
    always_ff @(posedge i_Clk) begin
        if (i_Reset || i_Clear) begin
            r_count <= '0;
        end else if (i_Tick && (r_count != FRAME_W'(FRAMES))) begin
            r_count <= r_count + FRAME_W'(1);
        end
    end

    assign o_Done_c = (r_count == FRAME_W'(FRAMES));

endmodule

// File: rtl/game_state_controller.sv
// Round/level sequencer: tracks lives and level, gates play, and sets the car step period.
module game_state_controller
    import game_state_controller_pkg::*;
#(
    parameter int unsigned LIVES_INI     = LIVES_INI_DEF,
    parameter int unsigned MAX_LEVEL     = MAX_LEVEL_DEF,
    parameter int unsigned FREEZE_FRAMES = FREEZE_FRAMES_DEF,
    parameter int unsigned WIN_Y         = WIN_Y_DEF,
    parameter int unsigned BASE_PERIOD   = BASE_PERIOD_DEF,
    parameter int unsigned PERIOD_STEP   = PERIOD_STEP_DEF
) (
    input logic                    i_Clk,
    input logic                    i_Reset,
    game_state_controller_if.slave bus
);

    state_e              r_state;
    logic [LIVES_W-1:0]  r_lives;
    logic [LEVEL_W-1:0]  r_level;
    logic [PERIOD_W-1:0] r_car_period;
    logic                r_frog_reset;
    logic                r_game_active;
    logic                r_sw_prev;
    logic                r_col_prev;

    logic                w_sw_rise;
    logic                w_col_rise;
    logic                w_win;
    logic                w_freeze_start;
    logic                w_freeze_tick;
    logic                w_freeze_done;
    logic [LEVEL_W-1:0]  w_level_next;

    assign w_sw_rise      = bus.i_Any_Switch & ~r_sw_prev;
    assign w_col_rise     = bus.i_Has_Collided & ~r_col_prev;
    assign w_win          = (bus.i_Frog_Y <= FROG_Y_W'(WIN_Y));
    assign w_freeze_start = (r_state == ST_PLAY) && (w_col_rise || w_win);
    assign w_freeze_tick  = bus.i_Frame_Tick && ((r_state == ST_HIT) || (r_state == ST_LEVEL_UP));
    assign w_level_next   = (r_level >= LEVEL_W'(MAX_LEVEL)) ? r_level : r_level + LEVEL_W'(1);

    game_state_controller_frame_delay_counter #(
        .FRAMES (FREEZE_FRAMES)
    ) u_freeze (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_Clear  (w_freeze_start),
        .i_Tick   (w_freeze_tick),
        .o_Done_c (w_freeze_done)
    );

    // Sequencer: frog-reset and game-active are set on the edge that enters PLAY.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state       <= ST_IDLE;
            r_lives       <= LIVES_W'(LIVES_INI);
            r_level       <= LEVEL_W'(1);
            r_car_period  <= PERIOD_W'(BASE_PERIOD);
            r_frog_reset  <= 1'b0;
            r_game_active <= 1'b0;
            r_sw_prev     <= 1'b0;
            r_col_prev    <= 1'b0;
        end else begin
            r_sw_prev    <= bus.i_Any_Switch;
            r_col_prev   <= bus.i_Has_Collided;
            r_frog_reset <= 1'b0;
            r_car_period <= car_period(PERIOD_W'(BASE_PERIOD), PERIOD_W'(PERIOD_STEP), r_level);
            case (r_state)
                ST_IDLE: begin
                    if (w_sw_rise) begin
                        r_state       <= ST_PLAY;
                        r_lives       <= LIVES_W'(LIVES_INI);
                        r_level       <= LEVEL_W'(1);
                        r_frog_reset  <= 1'b1;
                        r_game_active <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (w_col_rise) begin
                        r_state       <= ST_HIT;
                        r_lives       <= r_lives - LIVES_W'(1);
                        r_game_active <= 1'b0;
                    end else if (w_win) begin
                        r_state       <= ST_LEVEL_UP;
                        r_level       <= w_level_next;
                        r_game_active <= 1'b0;
                    end
                end
                ST_HIT: begin
                    if (w_freeze_done) begin
                        if (r_lives == '0) begin
                            r_state <= ST_OVER;
                        end else begin
                            r_state       <= ST_PLAY;
                            r_frog_reset  <= 1'b1;
                            r_game_active <= 1'b1;
                        end
                    end
                end
                ST_LEVEL_UP: begin
                    if (w_freeze_done) begin
                        r_state       <= ST_PLAY;
                        r_frog_reset  <= 1'b1;
                        r_game_active <= 1'b1;
                    end
                end
                ST_OVER: begin
                    if (w_sw_rise) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_game_active <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_State       = r_state;
    assign bus.o_Lives       = r_lives;
    assign bus.o_Level       = r_level;
    assign bus.o_Car_Period  = r_car_period;
    assign bus.o_Frog_Reset  = r_frog_reset;
    assign bus.o_Game_Active = r_game_active;

endmodule
